// File: rtl/alu_operand_collector.sv
// Operand collector ahead of the ALU core: gathers OPA/OPB (together or split), bounds the
// wait for the missing half, and presents one operation on a valid/ready port.
// Optional macro ALU_CMD_MISMATCH_CHECK_EN: drop split operations whose CMD/MODE changed.
module alu_operand_collector #(
    parameter int unsigned OP_WIDTH  = 8,
    parameter int unsigned CMD_WIDTH = 4,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CE,
    input  logic [1:0]           INP_VALID,
    input  logic [OP_WIDTH-1:0]  OPA,
    input  logic [OP_WIDTH-1:0]  OPB,
    input  logic [CMD_WIDTH-1:0] CMD,
    input  logic                 MODE,
    input  logic                 CIN,
    output logic                 IN_READY,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    output logic [OP_WIDTH-1:0]  OUT_OPA,
    output logic [OP_WIDTH-1:0]  OUT_OPB,
    output logic [CMD_WIDTH-1:0] OUT_CMD,
    output logic                 OUT_MODE,
    output logic                 OUT_CIN,
    output logic                 ERR_TIMEOUT,
    output logic                 ERR_MISMATCH
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] TimeoutC = CntW'(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWaitA, StWaitB, StHold} state_e;

    state_e                 r_state, w_state_nxt;
    logic [CntW-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [OP_WIDTH-1:0]    r_opa, w_opa_nxt;
    logic [OP_WIDTH-1:0]    r_opb, w_opb_nxt;
    logic [CMD_WIDTH-1:0]   r_cmd, w_cmd_nxt;
    logic                   r_mode, w_mode_nxt;
    logic                   r_cin, w_cin_nxt;
    logic                   r_err_to, w_err_to_nxt;
    logic                   w_err_mm_nxt;
    logic                   w_mismatch;
    logic                   w_done;

    assign IN_READY  = (r_state != StHold) || OUT_READY;
    assign OUT_VALID = (r_state == StHold);
    assign OUT_OPA   = r_opa;
    assign OUT_OPB   = r_opb;
    assign OUT_CMD   = r_cmd;
    assign OUT_MODE  = r_mode;
    assign OUT_CIN   = r_cin;
    assign ERR_TIMEOUT = r_err_to;

    assign w_cnt_inc = (r_cnt == TimeoutC) ? r_cnt : r_cnt + CntW'(1);

`ifdef ALU_CMD_MISMATCH_CHECK_EN
    // r_cmd/r_mode carry the first half's control while waiting.
    assign w_mismatch = (CMD != r_cmd) || (MODE != r_mode);

    logic r_err_mm;
    always_ff @(posedge CLK) begin
        if (RST) r_err_mm <= 1'b0;
        else     r_err_mm <= w_err_mm_nxt;
    end
    assign ERR_MISMATCH = r_err_mm;
`else
    assign w_mismatch   = 1'b0;
    assign ERR_MISMATCH = 1'b0;
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_opa_nxt    = r_opa;
        w_opb_nxt    = r_opb;
        w_cmd_nxt    = r_cmd;
        w_mode_nxt   = r_mode;
        w_cin_nxt    = r_cin;
        w_err_to_nxt = 1'b0;
        w_err_mm_nxt = 1'b0;
        w_done       = 1'b0;
        // CE low freezes everything; only the error pulses fall back to 0.
        if (CE) begin
            unique case (r_state)
                StIdle, StHold: begin
                    if (IN_READY) begin
                        w_state_nxt = StIdle;
                        w_cnt_nxt   = '0;
                        case (INP_VALID)
                            2'b11: begin
                                w_opa_nxt   = OPA;
                                w_opb_nxt   = OPB;
                                w_cmd_nxt   = CMD;
                                w_mode_nxt  = MODE;
                                w_cin_nxt   = CIN;
                                w_state_nxt = StHold;
                            end
                            2'b01: begin
                                w_opa_nxt   = OPA;
                                w_state_nxt = StWaitB;
`ifdef ALU_CMD_MISMATCH_CHECK_EN
                                w_cmd_nxt   = CMD;
                                w_mode_nxt  = MODE;
`endif
                            end
                            2'b10: begin
                                w_opb_nxt   = OPB;
                                w_state_nxt = StWaitA;
`ifdef ALU_CMD_MISMATCH_CHECK_EN
                                w_cmd_nxt   = CMD;
                                w_mode_nxt  = MODE;
`endif
                            end
                            default: ;
                        endcase
                    end
                end
                StWaitA, StWaitB: begin
                    w_done = (r_state == StWaitA) ? INP_VALID[0] : INP_VALID[1];
                    if (w_done && w_mismatch) begin
                        w_err_mm_nxt = 1'b1;
                        w_state_nxt  = StIdle;
                        w_cnt_nxt    = '0;
                        w_opa_nxt    = '0;
                        w_opb_nxt    = '0;
                    end else if (w_done) begin
                        if (INP_VALID[0]) w_opa_nxt = OPA;
                        if (INP_VALID[1]) w_opb_nxt = OPB;
                        w_cmd_nxt   = CMD;
                        w_mode_nxt  = MODE;
                        w_cin_nxt   = CIN;
                        w_cnt_nxt   = '0;
                        w_state_nxt = StHold;
                    end else if (w_cnt_inc == TimeoutC) begin
                        w_err_to_nxt = 1'b1;
                        w_state_nxt  = StIdle;
                        w_cnt_nxt    = '0;
                        w_opa_nxt    = '0;
                        w_opb_nxt    = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_opa    <= '0;
            r_opb    <= '0;
            r_cmd    <= '0;
            r_mode   <= 1'b0;
            r_cin    <= 1'b0;
            r_err_to <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_opa    <= w_opa_nxt;
            r_opb    <= w_opb_nxt;
            r_cmd    <= w_cmd_nxt;
            r_mode   <= w_mode_nxt;
            r_cin    <= w_cin_nxt;
            r_err_to <= w_err_to_nxt;
        end
    end

endmodule

// File: tb/tb_alu_operand_collector.sv
// Directed bench for alu_operand_collector (OP_WIDTH=8, CMD_WIDTH=4, TIMEOUT=16).
// Mismatch expectations follow ALU_CMD_MISMATCH_CHECK_EN when it is defined for the build.
module tb_alu_operand_collector;

    logic       CLK = 1'b0;
    logic       RST, CE, MODE, CIN, OUT_READY;
    logic [1:0] INP_VALID;
    logic [7:0] OPA, OPB;
    logic [3:0] CMD;
    logic       IN_READY, OUT_VALID, OUT_MODE, OUT_CIN, ERR_TIMEOUT, ERR_MISMATCH;
    logic [7:0] OUT_OPA, OUT_OPB;
    logic [3:0] OUT_CMD;

    int n_tests = 0;
    int n_fail  = 0;

    alu_operand_collector #(
        .OP_WIDTH (8),
        .CMD_WIDTH(4),
        .TIMEOUT  (16)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .CE          (CE),
        .INP_VALID   (INP_VALID),
        .OPA         (OPA),
        .OPB         (OPB),
        .CMD         (CMD),
        .MODE        (MODE),
        .CIN         (CIN),
        .IN_READY    (IN_READY),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_OPA     (OUT_OPA),
        .OUT_OPB     (OUT_OPB),
        .OUT_CMD     (OUT_CMD),
        .OUT_MODE    (OUT_MODE),
        .OUT_CIN     (OUT_CIN),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_MISMATCH(ERR_MISMATCH)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] a,
                           input logic [7:0] b);
        chk({tag, "_valid"}, 32'(OUT_VALID), 32'(v));
        chk({tag, "_opa"}, 32'(OUT_OPA), 32'(a));
        chk({tag, "_opb"}, 32'(OUT_OPB), 32'(b));
    endtask

    initial begin
        RST = 1'b1; CE = 1'b1; INP_VALID = 2'b00; OPA = '0; OPB = '0;
        CMD = '0; MODE = 1'b0; CIN = 1'b0; OUT_READY = 1'b1;

        // Reset: all outputs zero
        for (int i = 0; i < 2; i++) begin
            tick();
            chk_out("rst", 1'b0, 8'h00, 8'h00);
            chk("rst_cmd", 32'(OUT_CMD), 32'h0);
            chk("rst_ctl", 32'({OUT_MODE, OUT_CIN, ERR_TIMEOUT, ERR_MISMATCH}), 32'h0);
        end
        RST = 1'b0;
        #1 chk("rst_inready", 32'(IN_READY), 32'h1);

        // Both operands at once
        INP_VALID = 2'b11; OPA = 8'h0F; OPB = 8'h01; CMD = 4'h0; MODE = 1'b1;
        tick();
        chk_out("pair", 1'b1, 8'h0F, 8'h01);
        chk("pair_mode", 32'(OUT_MODE), 32'h1);
        INP_VALID = 2'b00;
        tick();
        chk("pair_drain", 32'(OUT_VALID), 32'h0);

        // Split arrival, completion on the last allowed edge
        INP_VALID = 2'b01; OPA = 8'hAA; CMD = 4'h1; MODE = 1'b0;
        tick();
        chk("split_wait", 32'(OUT_VALID), 32'h0);
        INP_VALID = 2'b00;
        repeat (15) tick();
        chk("split_noerr15", 32'({OUT_VALID, ERR_TIMEOUT}), 32'h0);
        INP_VALID = 2'b10; OPB = 8'h55;
        tick();
        chk_out("split_last", 1'b1, 8'hAA, 8'h55);
        chk("split_last_to", 32'(ERR_TIMEOUT), 32'h0);
        INP_VALID = 2'b00;
        tick();
        chk("split_after_to", 32'(ERR_TIMEOUT), 32'h0);

        // Timeout after 16 idle cycles
        INP_VALID = 2'b10; OPB = 8'h33;
        tick();
        INP_VALID = 2'b00;
        repeat (15) tick();
        chk("to_early", 32'(ERR_TIMEOUT), 32'h0);
        tick();
        chk("to_pulse", 32'(ERR_TIMEOUT), 32'h1);
        chk("to_novalid", 32'(OUT_VALID), 32'h0);
        tick();
        chk("to_clear", 32'(ERR_TIMEOUT), 32'h0);

        // Fresh start after timeout: counter restarted
        INP_VALID = 2'b01; OPA = 8'h11;
        tick();
        INP_VALID = 2'b00;
        repeat (15) tick();
        INP_VALID = 2'b10; OPB = 8'h22;
        tick();
        chk_out("fresh", 1'b1, 8'h11, 8'h22);
        chk("fresh_to", 32'(ERR_TIMEOUT), 32'h0);
        INP_VALID = 2'b00;
        tick();

        // CE low freezes the counter
        INP_VALID = 2'b01; OPA = 8'hC3;
        tick();
        CE = 1'b0; INP_VALID = 2'b00;
        repeat (20) tick();
        chk("ce_frozen", 32'({OUT_VALID, ERR_TIMEOUT}), 32'h0);
        CE = 1'b1; INP_VALID = 2'b10; OPB = 8'h3C;
        tick();
        chk_out("ce_done", 1'b1, 8'hC3, 8'h3C);
        chk("ce_to", 32'(ERR_TIMEOUT), 32'h0);

        // Backpressure: held operation stable, input stalled
        OUT_READY = 1'b0; INP_VALID = 2'b11; OPA = 8'hFF; OPB = 8'hEE;
        #1 chk("bp_inready", 32'(IN_READY), 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("bp_hold", 1'b1, 8'hC3, 8'h3C);
            chk("bp_inready_hold", 32'(IN_READY), 32'h0);
        end

        // Back-to-back transfers
        OUT_READY = 1'b1; OPA = 8'h12; OPB = 8'h34; CMD = 4'h7; CIN = 1'b1;
        #1 chk("b2b_inready", 32'(IN_READY), 32'h1);
        tick();
        chk_out("b2b_1", 1'b1, 8'h12, 8'h34);
        chk("b2b_1_ctl", 32'({OUT_CMD, OUT_CIN}), 32'({4'h7, 1'b1}));
        OPA = 8'h56; OPB = 8'h78; CMD = 4'h9; CIN = 1'b0;
        tick();
        chk_out("b2b_2", 1'b1, 8'h56, 8'h78);
        chk("b2b_2_ctl", 32'({OUT_CMD, OUT_CIN}), 32'({4'h9, 1'b0}));
        INP_VALID = 2'b00;
        tick();
        chk("b2b_drain", 32'(OUT_VALID), 32'h0);

        // Completion with both bits set overwrites the held operand
        INP_VALID = 2'b01; OPA = 8'hAB; CMD = 4'h5; MODE = 1'b1;
        tick();
        INP_VALID = 2'b11; OPA = 8'hCD; OPB = 8'hEF;
        tick();
        chk_out("overwrite", 1'b1, 8'hCD, 8'hEF);
        INP_VALID = 2'b00;
        tick();

        // CMD changes between halves
        INP_VALID = 2'b01; OPA = 8'h01; CMD = 4'h2; MODE = 1'b1;
        tick();
        INP_VALID = 2'b10; OPB = 8'h02; CMD = 4'h3;
        tick();
`ifdef ALU_CMD_MISMATCH_CHECK_EN
        chk("mm_pulse", 32'(ERR_MISMATCH), 32'h1);
        chk("mm_novalid", 32'(OUT_VALID), 32'h0);
        INP_VALID = 2'b00;
        tick();
        chk("mm_clear", 32'({ERR_MISMATCH, OUT_VALID}), 32'h0);
`else
        chk_out("mm_off", 1'b1, 8'h01, 8'h02);
        chk("mm_off_cmd", 32'(OUT_CMD), 32'h3);
        chk("mm_off_err", 32'(ERR_MISMATCH), 32'h0);
        INP_VALID = 2'b00;
        tick();
`endif

        // Reset mid-wait discards silently
        INP_VALID = 2'b01; OPA = 8'h77;
        tick();
        RST = 1'b1; INP_VALID = 2'b00;
        tick();
        chk_out("rst_mid", 1'b0, 8'h00, 8'h00);
        RST = 1'b0;
        for (int i = 0; i < 18; i++) begin
            tick();
            chk("rst_mid_noerr", 32'({ERR_TIMEOUT, OUT_VALID}), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
